cc_bus_source_mux_reg: RTL and testbench
========================================

// Module: cc_bus_source_mux_reg
// PURPOSE
//  Registered, parametrised bus-source selector for the datapath bus.
//  Selects one of NUM_CHANNELS packed data inputs by either a register-field index or a control index.
//  The result is registered with a valid flag, a hold/freeze mode and a sticky out-of-range error.
//  Sits between the register file / immediate sources and the ALU bus; replaces the purely combinational selector.
// PARAMETERS
//  DATAWIDTH_BUS                   4   width of each channel and of the output bus
//  NUM_CHANNELS                   12   number of selectable channels (legal indices 0..NUM_CHANNELS-1)
//  DATAWIDTH_MUX_SELECTION_REG     5   width of register-field index
//  DATAWIDTH_MUX_SELECTION_CONTROL 6   width of control index
// PORTS
//  CC_MUX_CLOCK_50        in   1   clock, rising edge
//  CC_MUX_RESET_InLow     in   1   asynchronous, active-low reset
//  CC_MUX_data_InBUS      in   NUM_CHANNELS*DATAWIDTH_BUS   packed channels; ch k = bits [k*W +: W]
//  CC_MUX_registro_InBUS  in   DATAWIDTH_MUX_SELECTION_REG      register-field index
//  CC_MUX_control_InBUS   in   DATAWIDTH_MUX_SELECTION_CONTROL  control index
//  CC_MUX_selector_InBUS  in   1   0 = use control index, 1 = use register index
//  CC_MUX_valid_In        in   1   request: sample inputs this cycle
//  CC_MUX_hold_In         in   1   freeze output register
//  CC_MUX_clrErr_In       in   1   clear sticky error
//  CC_MUX_data_OutBUS     out  DATAWIDTH_BUS   registered selected data
//  CC_MUX_valid_Out       out  1   data_OutBUS holds a result
//  CC_MUX_index_Out       out  DATAWIDTH_MUX_SELECTION_CONTROL  index latched with the current result
//  CC_MUX_err_Out         out  1   sticky: an out-of-range index was sampled
// BEHAVIOUR
//  Reset (async, RESET_InLow=0): data_OutBUS=0, valid_Out=0, index_Out=0, err_Out=0, state=IDLE.
//   Reset takes effect immediately mid-operation; first sample is possible on the first edge after release.
//  Index: selector=0 -> control index; selector=1 -> register index zero-extended to the control width.
//   The index is compared at full width against NUM_CHANNELS (no truncation).
//  Latency: 1 cycle. Inputs sampled at edge N appear on the outputs after edge N.
//  FSM states:
//   IDLE: valid_Out=0. valid_In & ~hold_In -> load, go DRIVE. Otherwise stay.
//   DRIVE: valid_Out=1. hold_In -> HELD (no load). valid_In -> load, stay.
//     ~valid_In -> keep data, stay (output persists, valid_Out stays 1).
//   HELD: outputs frozen, valid_In ignored (request dropped). ~hold_In -> DRIVE.
//     That edge also loads if valid_In=1.
//  hold_In in IDLE: stay IDLE, no load.
//  Load: index_Out <= index. If index < NUM_CHANNELS, data_OutBUS <= channel[index].
//   Else data_OutBUS <= 0 and err_Out <= 1; valid_Out still 1.
//  err_Out: sticky until clrErr_In=1 or reset. clrErr_In with a simultaneous out-of-range load -> err_Out=1 (set wins).
//  hold_In and valid_In both 1: hold wins, no load, in every state.
//  All outputs come from registers only; no combinational input->output path.
// TESTING
//  Reset: RESET_InLow=0 mid-DRIVE -> all outputs 0 immediately (before next edge), state IDLE.
//  Control path: ch3=4'hA, selector=0, control=3, valid=1 -> next cycle data=4'hA, valid_Out=1, index_Out=3.
//  Register path: ch11=4'h5, selector=1, registro=5'd11, control=0 -> data=4'h5, index_Out=11.
//  Out of range: control=6'd12 -> data=0, err_Out=1. Next load ch0=4'h7 -> data=7, err_Out still 1.
//   clrErr -> err_Out=0.
//  Hold: in DRIVE data=4'hA; hold=1 and valid=1 with ch2=4'h3 -> data stays A.
//   Release hold with valid=1, ch2 selected -> data=4'h3 the same edge.
//  Back-to-back: valid=1 for 4 cycles, indices 0,1,2,3 -> outputs follow each one cycle later, valid_Out never drops.

Source files
------------

// File: rtl/cc_bus_source_mux_reg_if.sv
// Bus bundle for the registered bus-source selector: channel data, index inputs,
// request/hold/clear controls and the registered result.
interface cc_bus_source_mux_reg_if #(
    parameter int DATAWIDTH_BUS                   = 4,
    parameter int NUM_CHANNELS                    = 12,
    parameter int DATAWIDTH_MUX_SELECTION_REG     = 5,
    parameter int DATAWIDTH_MUX_SELECTION_CONTROL = 6
) ();
    logic [NUM_CHANNELS*DATAWIDTH_BUS-1:0]    CC_MUX_data_InBUS;
    logic [DATAWIDTH_MUX_SELECTION_REG-1:0]     CC_MUX_registro_InBUS;
    logic [DATAWIDTH_MUX_SELECTION_CONTROL-1:0] CC_MUX_control_InBUS;
    logic                                       CC_MUX_selector_InBUS;
    logic                                       CC_MUX_valid_In;
    logic                                       CC_MUX_hold_In;
    logic                                       CC_MUX_clrErr_In;
    logic [DATAWIDTH_BUS-1:0]                   CC_MUX_data_OutBUS;
    logic                                       CC_MUX_valid_Out;
    logic [DATAWIDTH_MUX_SELECTION_CONTROL-1:0] CC_MUX_index_Out;
    logic                                       CC_MUX_err_Out;

    modport master (
        output CC_MUX_data_InBUS, CC_MUX_registro_InBUS, CC_MUX_control_InBUS,
        output CC_MUX_selector_InBUS, CC_MUX_valid_In, CC_MUX_hold_In, CC_MUX_clrErr_In,
        input  CC_MUX_data_OutBUS, CC_MUX_valid_Out, CC_MUX_index_Out, CC_MUX_err_Out
    );

    modport slave (
        input  CC_MUX_data_InBUS, CC_MUX_registro_InBUS, CC_MUX_control_InBUS,
        input  CC_MUX_selector_InBUS, CC_MUX_valid_In, CC_MUX_hold_In, CC_MUX_clrErr_In,
        output CC_MUX_data_OutBUS, CC_MUX_valid_Out, CC_MUX_index_Out, CC_MUX_err_Out
    );
endinterface

// File: rtl/cc_bus_source_mux_reg.sv
// Registered bus-source selector: picks one packed channel by register or control
// index, with valid flag, hold/freeze mode and sticky out-of-range error.
module cc_bus_source_mux_reg #(
    parameter int DATAWIDTH_BUS                   = 4,
    parameter int NUM_CHANNELS                    = 12,
    parameter int DATAWIDTH_MUX_SELECTION_REG     = 5,
    parameter int DATAWIDTH_MUX_SELECTION_CONTROL = 6
) (
    input  logic                     CC_MUX_CLOCK_50,
    input  logic                     CC_MUX_RESET_InLow,
    cc_bus_source_mux_reg_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_HELD  = 2'd2
    } state_t;

    // Returns channel[idx]; indices beyond the last channel yield zero.
    function automatic logic [DATAWIDTH_BUS-1:0] f_select_channel(
        input logic [NUM_CHANNELS*DATAWIDTH_BUS-1:0]    data,
        input logic [DATAWIDTH_MUX_SELECTION_CONTROL-1:0] idx
    );
        logic [DATAWIDTH_BUS-1:0] sel;
        sel = '0;
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            if (32'(idx) == k) begin
                sel = data[k*DATAWIDTH_BUS +: DATAWIDTH_BUS];
            end
        end
        return sel;
    endfunction

    state_t                                     r_state;
    logic [DATAWIDTH_BUS-1:0]                   r_data_p1;
    logic                                       r_vld_p1;
    logic [DATAWIDTH_MUX_SELECTION_CONTROL-1:0] r_index_p1;
    logic                                       r_err_p1;

    logic [DATAWIDTH_MUX_SELECTION_CONTROL-1:0] w_index;
    logic                                       w_in_range;
    logic                                       w_load;
    logic [DATAWIDTH_BUS-1:0]                   w_sel_data;

    // A load happens in every state exactly when a request arrives without hold.
    assign w_index    = bus.CC_MUX_selector_InBUS
                        ? DATAWIDTH_MUX_SELECTION_CONTROL'(bus.CC_MUX_registro_InBUS)
                        : bus.CC_MUX_control_InBUS;
    assign w_in_range = (32'(w_index) < NUM_CHANNELS);
    assign w_load     = bus.CC_MUX_valid_In & ~bus.CC_MUX_hold_In;
    assign w_sel_data = f_select_channel(bus.CC_MUX_data_InBUS, w_index);

    // Stage p0 -> p1: sample selection into the output registers
    always_ff @(posedge CC_MUX_CLOCK_50 or negedge CC_MUX_RESET_InLow) begin
        if (!CC_MUX_RESET_InLow) begin
            r_state    <= ST_IDLE;
            r_data_p1  <= '0;
            r_vld_p1   <= 1'b0;
            r_index_p1 <= '0;
            r_err_p1   <= 1'b0;
        end else begin
            if (w_load) begin
                r_data_p1  <= w_sel_data;
                r_index_p1 <= w_index;
            end

            // Set beats clear when both happen on the same edge.
            if (w_load && !w_in_range) begin
                r_err_p1 <= 1'b1;
            end else if (bus.CC_MUX_clrErr_In) begin
                r_err_p1 <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_load) begin
                        r_state  <= ST_DRIVE;
                        r_vld_p1 <= 1'b1;
                    end
                end
                ST_DRIVE: begin
                    if (bus.CC_MUX_hold_In) begin
                        r_state <= ST_HELD;
                    end
                end
                ST_HELD: begin
                    if (!bus.CC_MUX_hold_In) begin
                        r_state <= ST_DRIVE;
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_vld_p1 <= 1'b0;
                end
            endcase
        end
    end

    assign bus.CC_MUX_data_OutBUS = r_data_p1;
    assign bus.CC_MUX_valid_Out   = r_vld_p1;
    assign bus.CC_MUX_index_Out   = r_index_p1;
    assign bus.CC_MUX_err_Out     = r_err_p1;

endmodule

// File: tb/tb_cc_bus_source_mux_reg.sv
// Randomized self-checking bench for cc_bus_source_mux_reg against a
// load-event reference model.
module tb_cc_bus_source_mux_reg;

    localparam int W  = 4;
    localparam int N  = 12;
    localparam int RW = 5;
    localparam int CW = 6;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    cc_bus_source_mux_reg_if #(
        .DATAWIDTH_BUS(W), .NUM_CHANNELS(N),
        .DATAWIDTH_MUX_SELECTION_REG(RW), .DATAWIDTH_MUX_SELECTION_CONTROL(CW)
    ) bus ();

    cc_bus_source_mux_reg #(
        .DATAWIDTH_BUS(W), .NUM_CHANNELS(N),
        .DATAWIDTH_MUX_SELECTION_REG(RW), .DATAWIDTH_MUX_SELECTION_CONTROL(CW)
    ) dut (
        .CC_MUX_CLOCK_50   (clk),
        .CC_MUX_RESET_InLow(rst_n),
        .bus               (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Model: outputs change only on a load; valid is "a load happened since reset".
    logic [W-1:0]  m_data;
    logic          m_valid;
    logic [CW-1:0] m_idx;
    logic          m_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".data"},  32'(bus.CC_MUX_data_OutBUS), 32'(m_data));
        chk({tag, ".valid"}, 32'(bus.CC_MUX_valid_Out),   32'(m_valid));
        chk({tag, ".index"}, 32'(bus.CC_MUX_index_Out),   32'(m_idx));
        chk({tag, ".err"},   32'(bus.CC_MUX_err_Out),     32'(m_err));
    endtask

    task automatic model_reset();
        m_data  = '0;
        m_valid = 1'b0;
        m_idx   = '0;
        m_err   = 1'b0;
    endtask

    task automatic set_ch(input int k, input logic [W-1:0] v);
        bus.CC_MUX_data_InBUS[k*W +: W] = v;
    endtask

    task automatic model_edge();
        int idx;
        logic [N*W-1:0] sh;
        logic load;
        idx  = bus.CC_MUX_selector_InBUS ? int'(bus.CC_MUX_registro_InBUS)
                                         : int'(bus.CC_MUX_control_InBUS);
        load = bus.CC_MUX_valid_In && !bus.CC_MUX_hold_In;
        if (load) begin
            m_valid = 1'b1;
            m_idx   = CW'(idx);
            if (idx < N) begin
                sh     = bus.CC_MUX_data_InBUS >> (idx * W);
                m_data = sh[W-1:0];
            end else begin
                m_data = '0;
            end
        end
        if (load && idx >= N)               m_err = 1'b1;
        else if (bus.CC_MUX_clrErr_In)      m_err = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        bus.CC_MUX_data_InBUS     = '0;
        bus.CC_MUX_registro_InBUS = '0;
        bus.CC_MUX_control_InBUS  = '0;
        bus.CC_MUX_selector_InBUS = 1'b0;
        bus.CC_MUX_valid_In       = 1'b0;
        bus.CC_MUX_hold_In        = 1'b0;
        bus.CC_MUX_clrErr_In      = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #12;
        chk_all("reset");
        rst_n = 1'b1;

        // Control path
        set_ch(3, 4'hA);
        bus.CC_MUX_control_InBUS = 6'd3;
        bus.CC_MUX_valid_In      = 1'b1;
        step();
        chk_all("ctrl");
        chk("ctrl.lit_data", 32'(bus.CC_MUX_data_OutBUS), 32'hA);
        chk("ctrl.lit_idx",  32'(bus.CC_MUX_index_Out),   32'd3);

        // Register path
        set_ch(11, 4'h5);
        bus.CC_MUX_selector_InBUS = 1'b1;
        bus.CC_MUX_registro_InBUS = 5'd11;
        bus.CC_MUX_control_InBUS  = 6'd0;
        step();
        chk_all("reg");
        chk("reg.lit_data", 32'(bus.CC_MUX_data_OutBUS), 32'h5);
        chk("reg.lit_idx",  32'(bus.CC_MUX_index_Out),   32'd11);

        // Out of range, then sticky error across a good load, then clear
        bus.CC_MUX_selector_InBUS = 1'b0;
        bus.CC_MUX_control_InBUS  = 6'd12;
        step();
        chk_all("oor");
        chk("oor.lit_data", 32'(bus.CC_MUX_data_OutBUS), 32'h0);
        chk("oor.lit_err",  32'(bus.CC_MUX_err_Out),     32'd1);
        chk("oor.lit_vld",  32'(bus.CC_MUX_valid_Out),   32'd1);
        set_ch(0, 4'h7);
        bus.CC_MUX_control_InBUS = 6'd0;
        step();
        chk_all("sticky");
        chk("sticky.lit_data", 32'(bus.CC_MUX_data_OutBUS), 32'h7);
        chk("sticky.lit_err",  32'(bus.CC_MUX_err_Out),     32'd1);
        bus.CC_MUX_valid_In  = 1'b0;
        bus.CC_MUX_clrErr_In = 1'b1;
        step();
        chk_all("clr");
        chk("clr.lit_err", 32'(bus.CC_MUX_err_Out), 32'd0);

        // Clear together with an out-of-range load: set wins
        bus.CC_MUX_valid_In      = 1'b1;
        bus.CC_MUX_control_InBUS = 6'd63;
        step();
        chk_all("setwins");
        chk("setwins.lit_err", 32'(bus.CC_MUX_err_Out), 32'd1);

        // Register index 31 compared at full width
        bus.CC_MUX_clrErr_In      = 1'b0;
        bus.CC_MUX_selector_InBUS = 1'b1;
        bus.CC_MUX_registro_InBUS = 5'd31;
        step();
        chk_all("reg31");
        chk("reg31.lit_idx", 32'(bus.CC_MUX_index_Out), 32'd31);

        // Hold: data frozen, request dropped; release reloads on the same edge
        bus.CC_MUX_clrErr_In      = 1'b1;
        bus.CC_MUX_selector_InBUS = 1'b0;
        bus.CC_MUX_control_InBUS  = 6'd3;
        step();
        bus.CC_MUX_clrErr_In = 1'b0;
        chk("hold.pre_data", 32'(bus.CC_MUX_data_OutBUS), 32'hA);
        set_ch(2, 4'h3);
        bus.CC_MUX_hold_In       = 1'b1;
        bus.CC_MUX_control_InBUS = 6'd2;
        step();
        chk_all("hold1");
        chk("hold1.lit_data", 32'(bus.CC_MUX_data_OutBUS), 32'hA);
        step();
        chk_all("hold2");
        chk("hold2.lit_data", 32'(bus.CC_MUX_data_OutBUS), 32'hA);
        bus.CC_MUX_hold_In = 1'b0;
        step();
        chk_all("release");
        chk("release.lit_data", 32'(bus.CC_MUX_data_OutBUS), 32'h3);

        // Back-to-back loads
        for (int i = 0; i < 4; i++) begin
            set_ch(i, W'(i + 8));
            bus.CC_MUX_control_InBUS = CW'(i);
            step();
            chk_all("b2b");
            chk("b2b.lit_data", 32'(bus.CC_MUX_data_OutBUS), 32'(i + 8));
            chk("b2b.lit_vld",  32'(bus.CC_MUX_valid_Out),   32'd1);
        end

        // Asynchronous reset mid-DRIVE takes effect before the next edge
        bus.CC_MUX_valid_In = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.data",  32'(bus.CC_MUX_data_OutBUS), 32'd0);
        chk("arst.valid", 32'(bus.CC_MUX_valid_Out),   32'd0);
        chk("arst.index", 32'(bus.CC_MUX_index_Out),   32'd0);
        chk("arst.err",   32'(bus.CC_MUX_err_Out),     32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Hold in IDLE blocks the load
        bus.CC_MUX_valid_In = 1'b1;
        bus.CC_MUX_hold_In  = 1'b1;
        step();
        chk_all("idlehold");
        bus.CC_MUX_hold_In       = 1'b0;
        bus.CC_MUX_control_InBUS = 6'd1;
        step();
        chk_all("idleload");

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            bus.CC_MUX_data_InBUS     = {$urandom, $urandom};
            bus.CC_MUX_selector_InBUS = 1'($urandom_range(0, 1));
            bus.CC_MUX_registro_InBUS = RW'($urandom_range(0, 31));
            bus.CC_MUX_control_InBUS  = ($urandom_range(0, 7) == 0) ? CW'($urandom_range(0, 63))
                                                                    : CW'($urandom_range(0, 13));
            bus.CC_MUX_valid_In       = ($urandom_range(0, 9) < 7);
            bus.CC_MUX_hold_In        = ($urandom_range(0, 9) < 2);
            bus.CC_MUX_clrErr_In      = ($urandom_range(0, 9) < 1);
            step();
            chk_all("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
